// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit single-bus microsequencer.
// Holds the state encoding, the opcode map, the instruction fields and the control-strobe bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH0, FETCH1, OPA0, OPA1, MEM, EX0, EX1, HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_MSB    = 7;
    localparam int OP_LSB    = 4;
    localparam int ALUOP_MSB = 5;
    localparam int ALUOP_LSB = 4;
    localparam int SUB_BIT   = 3;
    localparam int RS_BIT    = 1;
    localparam int RD_BIT    = 0;

    typedef struct packed {
        logic       aluOE;
        logic       aluSubShiftDir;
        logic       aluBWr;
        logic [1:0] aluOp;
        logic       regWr0;
        logic       regWr1;
        logic       regBusSel;
        logic       regBusEn;
        logic       aluSel;
        logic       ramAddressEn;
        logic       ramWriteEn;
        logic       ramReadDataSelect;
        logic       ramOE;
        logic       loadPC;
        logic       incrPC;
        logic       pcOE;
    } ctrl_t;

    function automatic logic isTwoByte(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
    endfunction

    // Opcodes 0x4-0x7 are the ALU group.
    function automatic logic isAlu(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode from registered state and IR.
// Only i_run (FETCH0) and the ALU flags (OPA1) enter here besides registered state.
import cpu_pkg::*;

module control_decode (
    input  state_t     state,
    input  logic [7:0] ir,
    input  logic       run,
    input  logic       flagN,
    input  logic       flagZ,
    output ctrl_t      ctrl
);

    logic [3:0] op;
    logic       rd;
    logic       rs;
    logic       unusedIrBit;

    assign op          = ir[OP_MSB:OP_LSB];
    assign rd          = ir[RD_BIT];
    assign rs          = ir[RS_BIT];
    assign unusedIrBit = ir[2];

    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH0: begin
                ctrl.pcOE         = run;
                ctrl.ramAddressEn = run;
            end
            FETCH1: begin
                ctrl.ramOE  = 1'b1;
                ctrl.incrPC = 1'b1;
            end
            OPA0: begin
                ctrl.pcOE         = 1'b1;
                ctrl.ramAddressEn = 1'b1;
            end
            OPA1: begin
                ctrl.ramOE = 1'b1;
                case (op)
                    OP_LDI: begin
                        ctrl.incrPC = 1'b1;
                        ctrl.regWr0 = ~rd;
                        ctrl.regWr1 = rd;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.incrPC       = 1'b1;
                        ctrl.ramAddressEn = 1'b1;
                    end
                    OP_JMP: ctrl.loadPC = 1'b1;
                    OP_JN: begin
                        ctrl.loadPC = flagN;
                        ctrl.incrPC = ~flagN;
                    end
                    OP_JZ: begin
                        ctrl.loadPC = flagZ;
                        ctrl.incrPC = ~flagZ;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                if (op == OP_ST) begin
                    ctrl.regBusEn   = 1'b1;
                    ctrl.regBusSel  = rs;
                    ctrl.ramWriteEn = 1'b1;
                end else begin
                    ctrl.ramOE  = 1'b1;
                    ctrl.regWr0 = ~rd;
                    ctrl.regWr1 = rd;
                end
            end
            EX0: begin
                ctrl.regBusEn  = 1'b1;
                ctrl.regBusSel = rs;
                ctrl.aluBWr    = 1'b1;
                ctrl.aluSel    = rd;
            end
            EX1: begin
                ctrl.aluOE          = 1'b1;
                ctrl.aluSel         = rd;
                ctrl.aluOp          = ir[ALUOP_MSB:ALUOP_LSB];
                ctrl.aluSubShiftDir = ir[SUB_BIT];
                ctrl.regWr0         = ~rd;
                ctrl.regWr1         = rd;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle microsequencer: fetches instruction bytes over the shared bus and sequences datapath strobes.
//
// state  | meaning
// FETCH0 | PC drives address for opcode byte (waits here while i_run low)
// FETCH1 | RAM drives opcode onto bus, IR captured, PC incremented
// OPA0   | PC drives address for operand byte
// OPA1   | RAM drives operand: immediate load, address latch or jump
// MEM    | LD reads RAM into rd / ST writes rs to RAM
// EX0    | rs latched into ALU B
// EX1    | ALU result written to rd
// HALT   | idle until reset
import cpu_pkg::*;

module control_unit (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic [7:0] i_bus,
    input  logic       i_aluFlagN,
    input  logic       i_aluFlagZ,
    output logic       o_ctrlAluOE,
    output logic       o_ctrlAluSubShiftDir,
    output logic       o_ctrlAluBWr,
    output logic [1:0] o_ctrlAluOp,
    output logic       o_ctrlRegWr0,
    output logic       o_ctrlRegWr1,
    output logic       o_ctrlRegBusSel,
    output logic       o_ctrlRegBusEn,
    output logic       o_ctrlAluSel,
    output logic       o_ctrlRamAddressEn,
    output logic       o_ctrlRamWriteEn,
    output logic       o_ctrlRamReadDataSelect,
    output logic       o_ctrlRamOE,
    output logic       o_ctrlLoadPC,
    output logic       o_ctrlIncrPC,
    output logic       o_ctrlPCOe,
    output logic       o_halted,
    output logic [7:0] o_ir
);

    state_t     state, stateNext;
    logic [7:0] ir;
    ctrl_t      ctrl, ctrlOut;
    logic [3:0] busOp;
    logic [3:0] irOp;

    assign busOp = i_bus[OP_MSB:OP_LSB];
    assign irOp  = ir[OP_MSB:OP_LSB];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= FETCH0;
            ir    <= 8'h00;
        end else begin
            state <= stateNext;
            if (state == FETCH1)
                ir <= i_bus;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            FETCH0: if (i_run) stateNext = FETCH1;
            FETCH1: begin
                if (isTwoByte(busOp))     stateNext = OPA0;
                else if (isAlu(busOp))    stateNext = EX0;
                else if (busOp == OP_HLT) stateNext = HALT;
                else                      stateNext = FETCH0;
            end
            OPA0:    stateNext = OPA1;
            OPA1:    stateNext = (irOp == OP_LD || irOp == OP_ST) ? MEM : FETCH0;
            MEM:     stateNext = FETCH0;
            EX0:     stateNext = EX1;
            EX1:     stateNext = FETCH0;
            HALT:    stateNext = HALT;
            default: stateNext = FETCH0;
        endcase
    end

    control_decode uDecode (
        .state (state),
        .ir    (ir),
        .run   (i_run),
        .flagN (i_aluFlagN),
        .flagZ (i_aluFlagZ),
        .ctrl  (ctrl)
    );

    // FETCH0 strobes follow i_run combinationally, so gate everything while reset is held.
    assign ctrlOut = i_reset ? ctrl : '0;

    assign o_ctrlAluOE             = ctrlOut.aluOE;
    assign o_ctrlAluSubShiftDir    = ctrlOut.aluSubShiftDir;
    assign o_ctrlAluBWr            = ctrlOut.aluBWr;
    assign o_ctrlAluOp             = ctrlOut.aluOp;
    assign o_ctrlRegWr0            = ctrlOut.regWr0;
    assign o_ctrlRegWr1            = ctrlOut.regWr1;
    assign o_ctrlRegBusSel         = ctrlOut.regBusSel;
    assign o_ctrlRegBusEn          = ctrlOut.regBusEn;
    assign o_ctrlAluSel            = ctrlOut.aluSel;
    assign o_ctrlRamAddressEn      = ctrlOut.ramAddressEn;
    assign o_ctrlRamWriteEn        = ctrlOut.ramWriteEn;
    assign o_ctrlRamReadDataSelect = ctrlOut.ramReadDataSelect;
    assign o_ctrlRamOE             = ctrlOut.ramOE;
    assign o_ctrlLoadPC            = ctrlOut.loadPC;
    assign o_ctrlIncrPC            = ctrlOut.incrPC;
    assign o_ctrlPCOe              = ctrlOut.pcOE;
    assign o_halted                = i_reset && (state == HALT);
    assign o_ir                    = ir;

endmodule
